stored_carry_accumulator: RTL and testbench
===========================================

Name: stored_carry_accumulator

Overview:
- Streaming accumulator that keeps its running total in stored-carry form: a sum vector plus a carry vector.
- Each accepted operand is added in one cycle with a single carry-save row, so there is no carry propagation on the accumulate path.
- On the last operand, the block resolves the stored-carry total to binary over several cycles, CHUNK bits per cycle, and presents the result on a valid/ready output.
- It is the sequential, parametrised successor of the combinational stored-carry adder chain and binary converter, for use in multiply/accumulate datapaths.

Parameters:
- LEN, 16, accumulator width; all arithmetic is modulo 2^LEN.
- IN_W, 8, operand width; must satisfy 1 <= IN_W <= LEN.
- CHUNK, 4, bits resolved per cycle during conversion; must satisfy 1 <= CHUNK <= LEN.
- SIGNED, 0, 1 = sign-extend operands to LEN bits, 0 = zero-extend.
- CNT_W, 8, width of the operand counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  operand valid.
- in_ready  out  1  block can accept an operand.
- in_data  in  IN_W  operand.
- in_last  in  1  operand is the final one of the accumulation; qualified by in_valid.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  LEN  binary sum modulo 2^LEN.
- out_count  out  CNT_W  number of operands accumulated, modulo 2^CNT_W.
- busy  out  1  high while in RESOLVE or OUTPUT.

Behaviour:
- Reset (asynchronous): state=ACCUM; sum vector, carry vector, chunk index, chunk carry and count all cleared to 0. Output reset values: in_ready=1, out_valid=0, out_data=0, out_count=0, busy=0.
- Accumulate step (ACCUM, fires when in_valid & in_ready):
  - x = extend(in_data).
  - sum' = S ^ C ^ x.
  - carry' = (maj(S,C,x) << 1), truncated to LEN bits; the MSB carry-out is discarded.
  - count increments by 1.
- State ACCUM:
  - in_ready=1.
  - A handshake with in_last=1 performs the step, then moves to RESOLVE with chunk index k=0 and chunk carry cin=0.
- State RESOLVE:
  - in_ready=0, busy=1.
  - Each cycle, add bits [k*CHUNK +: CHUNK] of S and C with cin; write the result bits into the output register and register the carry-out as the new cin.
  - k increments each cycle.
  - NCH = ceil(LEN/CHUNK). The final chunk may be partial; bits above LEN-1 are ignored and its carry-out is discarded.
  - After chunk NCH-1 the state moves to OUTPUT.
- State OUTPUT:
  - out_valid=1; out_data and out_count stay stable until out_ready is seen.
  - On out_valid & out_ready: S, C, count, k and cin clear to 0 and the state returns to ACCUM.
  - in_ready rises in the cycle after the output handshake.
- Latency: last operand accepted at edge t gives out_valid high from edge t+NCH+1. With defaults (NCH=4), that is 5 cycles.
- Throughput: one operand per cycle in ACCUM; no input is accepted during RESOLVE or OUTPUT.
- Boundary cases:
  - An accumulation of a single operand that carries in_last is legal.
  - Sum overflow wraps modulo 2^LEN with no flag.
  - The counter wraps modulo 2^CNT_W.
  - out_ready held high early has no effect until OUTPUT.
  - Inputs without in_valid are ignored; in_last without in_valid is ignored.
  - Reset asserted mid-RESOLVE or mid-OUTPUT aborts the operation: the partial result is lost and out_valid drops immediately.
  - CHUNK=LEN gives NCH=1 (one-cycle resolve).
- Invariant: the integer value (S + C) mod 2^LEN always equals the true running sum mod 2^LEN.

Decomposition:
- Package stored_carry_pkg holds:
  - the enum state_t {ACCUM, RESOLVE, OUTPUT};
  - a function num_chunks(LEN, CHUNK) returning the ceiling division;
  - a typedef for the stored-carry pair used to hold S and C.
- One combinational sub-module, sc_compress_row #(LEN): takes S, C and x and produces sum' and carry', one full adder per bit.
- The chunked resolver and the FSM live in the top module.

Test Plan:
- Defaults; operands 3, 5, 7, last on 7 -> out_data=15, out_count=3, out_valid exactly 5 cycles after the 7 handshake.
- Defaults; 300 operands of 0xFF, last on the final one -> out_data=(300*255) mod 65536=10964, out_count=300 mod 256=44.
- SIGNED=1; operands 0x05, 0xFE(-2), 0xFF(-1), last on 0xFF -> out_data=0x0002. Same stimulus with SIGNED=0 -> 0x0202.
- LEN=10, CHUNK=4 (NCH=3, partial top chunk); operands 1023, 1, last on 1 -> out_data=0, latency 4 cycles.
- Hold out_ready=0 for 7 cycles in OUTPUT -> out_data and out_valid stable and in_ready=0 throughout; on release, in_ready=1 next cycle and a new accumulation of 9 (last) -> out_data=9.
- Assert rst during cycle 2 of RESOLVE -> out_valid=0, in_ready=1 immediately; new single operand 4 (last) -> out_data=4, out_count=1.

Source files
------------

// File: rtl/stored_carry_pkg.sv
// Shared types and helpers for the stored-carry accumulator.
// Holds the FSM encoding, the S/C pair type and the chunk-count helper.
package stored_carry_pkg;

  // Storage width of the S/C pair; LEN + CHUNK must not exceed it.
  localparam int SC_MAX_W = 128;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  typedef struct packed {
    logic [SC_MAX_W-1:0] s;
    logic [SC_MAX_W-1:0] c;
  } sc_pair_t;

  function automatic int num_chunks(input int len, input int chunk);
    return (len + chunk - 1) / chunk;
  endfunction

endpackage

// File: rtl/sc_compress_row.sv
// One carry-save row: a full adder per bit folding operand x into the (S, C) pair.
// The carry vector is shifted up one place and its top carry-out is dropped (mod 2^LEN).
module sc_compress_row #(
  parameter int LEN = 16
) (
  input  logic [LEN-1:0] i_s,
  input  logic [LEN-1:0] i_c,
  input  logic [LEN-1:0] i_x,
  output logic [LEN-1:0] o_sum,
  output logic [LEN-1:0] o_carry
);

  logic [LEN-1:0] w_maj;

  assign o_sum   = i_s ^ i_c ^ i_x;
  assign w_maj   = (i_s & i_c) | (i_s & i_x) | (i_c & i_x);
  assign o_carry = w_maj << 1;

endmodule

// File: rtl/stored_carry_accumulator.sv
// Streaming accumulator kept in stored-carry form, resolved to binary CHUNK bits per cycle.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high; valid never waits on ready.
module stored_carry_accumulator
  import stored_carry_pkg::*;
#(
  parameter int LEN    = 16,
  parameter int IN_W   = 8,
  parameter int CHUNK  = 4,
  parameter int SIGNED = 0,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LEN-1:0]   out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             busy
);

  localparam int NCH = num_chunks(LEN, CHUNK);
  localparam int KW  = $clog2(NCH) + 1;

  state_t           r_state;
  sc_pair_t         r_acc;
  logic [KW-1:0]    r_k;
  logic             r_cin;
  logic [CNT_W-1:0] r_count;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;
  logic [LEN-1:0]   r_out_data;

  logic [LEN-1:0]   w_x;
  logic [LEN-1:0]   w_sum;
  logic [LEN-1:0]   w_carry;
  logic [CHUNK:0]   w_add;
  logic [LEN-1:0]   w_chunk;
  logic             w_fire;

  assign w_fire = in_valid & r_in_ready;
  assign w_x    = (SIGNED != 0) ? LEN'($signed(in_data)) : LEN'(in_data);

  sc_compress_row #(.LEN(LEN)) u_row (
    .i_s    (r_acc.s[LEN-1:0]),
    .i_c    (r_acc.c[LEN-1:0]),
    .i_x    (w_x),
    .o_sum  (w_sum),
    .o_carry(w_carry)
  );

  // S and C are stored zero above LEN, so a partial top chunk simply adds zeros;
  // the shift into the LEN-bit result then drops its out-of-range bits.
  assign w_add = (CHUNK+1)'(r_acc.s[int'(r_k)*CHUNK +: CHUNK])
               + (CHUNK+1)'(r_acc.c[int'(r_k)*CHUNK +: CHUNK])
               + (CHUNK+1)'(r_cin);
  assign w_chunk = LEN'(w_add[CHUNK-1:0]) << (int'(r_k) * CHUNK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ACCUM;
      r_acc       <= '0;
      r_k         <= '0;
      r_cin       <= 1'b0;
      r_count     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_out_data  <= '0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (w_fire) begin
            r_acc.s <= SC_MAX_W'(w_sum);
            r_acc.c <= SC_MAX_W'(w_carry);
            r_count <= r_count + CNT_W'(1);
            if (in_last) begin
              r_state    <= RESOLVE;
              r_k        <= '0;
              r_cin      <= 1'b0;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b1;
              r_out_data <= '0;
            end
          end
        end
        RESOLVE: begin
          r_out_data <= r_out_data | w_chunk;
          r_cin      <= w_add[CHUNK];
          r_k        <= r_k + KW'(1);
          if (r_k == KW'(NCH - 1)) r_state <= OUTPUT;
        end
        OUTPUT: begin
          // out_valid rises one cycle after the final chunk lands.
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_state     <= ACCUM;
            r_acc       <= '0;
            r_count     <= '0;
            r_k         <= '0;
            r_cin       <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_count = r_count;
  assign busy      = r_busy;

endmodule

// File: tb/tb_stored_carry_accumulator.sv
// Directed bench for stored_carry_accumulator: unsigned default, signed, and LEN=10 instances.
module tb_stored_carry_accumulator;

  logic       clk;
  logic       rst;
  logic       in_valid  [3];
  logic       in_last   [3];
  logic       out_ready [3];
  logic [7:0] in_data   [3];
  logic       in_ready  [3];
  logic       out_valid [3];
  logic       busy      [3];
  logic [7:0] oc        [3];
  logic [15:0] od0, od1;
  logic [9:0]  od2;

  int errors;
  int checks;
  int model_sum [3];
  int model_cnt [3];
  logic [15:0] exp_q[$];
  logic [7:0]  expc_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  stored_carry_accumulator u0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]), .in_last(in_last[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(od0), .out_count(oc[0]),
    .busy(busy[0])
  );

  stored_carry_accumulator #(.SIGNED(1)) u1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]), .in_last(in_last[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(od1), .out_count(oc[1]),
    .busy(busy[1])
  );

  stored_carry_accumulator #(.LEN(10), .CHUNK(4)) u2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]), .in_last(in_last[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(od2), .out_count(oc[2]),
    .busy(busy[2])
  );

  function automatic logic [15:0] od(input int u);
    case (u)
      0:       return od0;
      1:       return od1;
      default: return {6'b0, od2};
    endcase
  endfunction

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input int u, input logic [7:0] d, input logic last);
    int ext;
    check("in_ready_before_send", 32'(in_ready[u]), 1);
    in_valid[u] = 1'b1;
    in_data[u]  = d;
    in_last[u]  = last;
    ext = (u == 1) ? int'($signed(d)) : int'(d);
    model_sum[u] += ext;
    model_cnt[u]++;
    if (last) begin
      exp_q.push_back((u == 2) ? 16'(model_sum[u] & 32'h3FF) : 16'(model_sum[u] & 32'hFFFF));
      expc_q.push_back(8'(model_cnt[u] & 32'hFF));
      model_sum[u] = 0;
      model_cnt[u] = 0;
    end
    @(posedge clk); #1;
    in_valid[u] = 1'b0;
    in_last[u]  = 1'b0;
    in_data[u]  = 8'($urandom);
  endtask

  task automatic collect(input int u, input int lat, input int hold, input string tag);
    int n;
    logic [15:0] ed;
    logic [7:0]  ec;
    n = 0;
    while (!out_valid[u] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    ed = exp_q.pop_front();
    ec = expc_q.pop_front();
    if (!out_valid[u]) begin
      check({tag, "_timeout"}, 32'(out_valid[u]), 1);
      return;
    end
    if (lat > 0) check({tag, "_latency"}, 32'(n), 32'(lat));
    for (int h = 0; h < hold; h++) begin
      check({tag, "_hold_valid"}, 32'(out_valid[u]), 1);
      check({tag, "_hold_data"}, 32'(od(u)), 32'(ed));
      check({tag, "_hold_in_ready"}, 32'(in_ready[u]), 0);
      @(posedge clk); #1;
    end
    check({tag, "_data"}, 32'(od(u)), 32'(ed));
    check({tag, "_count"}, 32'(oc[u]), 32'(ec));
    out_ready[u] = 1'b1;
    @(posedge clk); #1;
    out_ready[u] = 1'b0;
    check({tag, "_valid_drop"}, 32'(out_valid[u]), 0);
    check({tag, "_in_ready_back"}, 32'(in_ready[u]), 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n_ops;
    errors = 0;
    checks = 0;
    for (int u = 0; u < 3; u++) begin
      in_valid[u] = 1'b0; in_last[u] = 1'b0; out_ready[u] = 1'b0; in_data[u] = 8'h00;
      model_sum[u] = 0; model_cnt[u] = 0;
    end
    rst = 1'b1;
    #12;
    for (int u = 0; u < 3; u++) begin
      check("rst_in_ready", 32'(in_ready[u]), 1);
      check("rst_out_valid", 32'(out_valid[u]), 0);
      check("rst_out_data", 32'(od(u)), 0);
      check("rst_out_count", 32'(oc[u]), 0);
      check("rst_busy", 32'(busy[u]), 0);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // 3 + 5 + 7 = 15, valid 5 cycles after the last handshake
    send(0, 8'd3, 1'b0); send(0, 8'd5, 1'b0); send(0, 8'd7, 1'b1);
    check("resolve_busy", 32'(busy[0]), 1);
    check("resolve_in_ready", 32'(in_ready[0]), 0);
    collect(0, 5, 0, "basic");

    // 300 x 0xFF: sum wraps to 10964, count wraps to 44
    for (int i = 0; i < 300; i++) send(0, 8'hFF, (i == 299));
    collect(0, 5, 0, "wrap");

    // signed vs unsigned extension of the same stimulus
    send(1, 8'h05, 1'b0); send(1, 8'hFE, 1'b0); send(1, 8'hFF, 1'b1);
    collect(1, 5, 0, "signed");
    send(0, 8'h05, 1'b0); send(0, 8'hFE, 1'b0); send(0, 8'hFF, 1'b1);
    collect(0, 5, 0, "unsigned");

    // LEN=10, partial top chunk: 1023 + 1 wraps to 0 in 4 cycles
    send(2, 8'hFF, 1'b0); send(2, 8'hFF, 1'b0); send(2, 8'hFF, 1'b0);
    send(2, 8'hFF, 1'b0); send(2, 8'd3, 1'b0); send(2, 8'd1, 1'b1);
    collect(2, 4, 0, "len10");

    // out_ready withheld for 7 cycles, then a fresh accumulation of 9
    send(0, 8'h11, 1'b0); send(0, 8'h22, 1'b1);
    collect(0, 5, 7, "hold");
    send(0, 8'd9, 1'b1);
    collect(0, 5, 0, "after_hold");

    // in_last without in_valid must not start a resolve
    in_last[0] = 1'b1; in_data[0] = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("ghost_last_busy", 32'(busy[0]), 0);
    end
    in_last[0] = 1'b0;

    // out_ready held high early has no effect before OUTPUT
    out_ready[0] = 1'b1;
    send(0, 8'd100, 1'b0); send(0, 8'd200, 1'b1);
    check("early_ready_no_valid", 32'(out_valid[0]), 0);
    collect(0, 5, 0, "early_ready");

    // random accumulations on unsigned and signed instances
    for (int r = 0; r < 4; r++) begin
      n_ops = $urandom_range(1, 6);
      for (int i = 0; i < n_ops; i++) send(r % 2, 8'($urandom_range(0, 255)), (i == n_ops - 1));
      collect(r % 2, 5, 0, "random");
    end

    // reset during the second RESOLVE cycle aborts the result
    send(0, 8'd3, 1'b0); send(0, 8'd5, 1'b1);
    void'(exp_q.pop_front());
    void'(expc_q.pop_front());
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_out_valid", 32'(out_valid[0]), 0);
    check("abort_in_ready", 32'(in_ready[0]), 1);
    check("abort_busy", 32'(busy[0]), 0);
    check("abort_count", 32'(oc[0]), 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    send(0, 8'd4, 1'b1);
    collect(0, 5, 0, "after_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
